ysyx_23060201_mem_arbiter: RTL

//  Shares the single DPI-backed physical-memory port between the IFU (read-only) and the LSU (read/write).

---
 rtl/ysyx_23060201_mem_arbiter_pkg.sv | 19 +
 rtl/ysyx_23060201_rr_arb2.sv | 25 ++
 rtl/ysyx_23060201_mem_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/ysyx_23060201_mem_arbiter_pkg.sv
// Shared types for the IFU/LSU memory arbiter: FSM state encoding, owner
// encoding and the latency counter width.
package ysyx_23060201_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWNER_IFU = 1'b0,
    OWNER_LSU = 1'b1
  } owner_t;

  localparam int CNT_W = 4;

endpackage

// File: rtl/ysyx_23060201_rr_arb2.sv
// Two-input round-robin grant: a lone requester always wins; on a conflict the
// requester that did not win last time is granted.
module ysyx_23060201_rr_arb2
  import ysyx_23060201_mem_arbiter_pkg::*;
(
  input  logic   req_ifu,
  input  logic   req_lsu,
  input  owner_t last_grant,
  output logic   gnt_ifu,
  output logic   gnt_lsu
);

  always_comb begin
    gnt_ifu = 1'b0;
    gnt_lsu = 1'b0;
    if (req_ifu && req_lsu) begin
      if (last_grant == OWNER_LSU) gnt_ifu = 1'b1;
      else                         gnt_lsu = 1'b1;
    end else begin
      gnt_ifu = req_ifu;
      gnt_lsu = req_lsu;
    end
  end

endmodule

// File: rtl/ysyx_23060201_mem_arbiter.sv
// Shares one physical-memory port between IFU (reads) and LSU (reads/writes):
// one transaction at a time, a single-cycle memory strobe, then a latency wait.
module ysyx_23060201_mem_arbiter
  import ysyx_23060201_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0] ifu_req_addr,
  output logic                  ifu_resp_valid,
  input  logic                  ifu_resp_ready,
  output logic [DATA_WIDTH-1:0] ifu_resp_rdata,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic                  lsu_req_wen,
  input  logic [ADDR_WIDTH-1:0] lsu_req_addr,
  input  logic [DATA_WIDTH-1:0] lsu_req_wdata,
  input  logic [7:0]            lsu_req_wmask,
  output logic                  lsu_resp_valid,
  input  logic                  lsu_resp_ready,
  output logic [DATA_WIDTH-1:0] lsu_resp_rdata,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [7:0]            mem_wmask
);

  // WAIT is left when the counter is 0, so it starts at LATENCY-1.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

  state_t                state, state_nxt;
  owner_t                last_grant, owner_q;
  logic                  wen_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic [7:0]            wmask_q;
  logic [CNT_W-1:0]      cnt;
  logic                  gnt_ifu, gnt_lsu, hs_ifu, hs_lsu, owner_ready;

  ysyx_23060201_rr_arb2 u_arb (
    .req_ifu    (ifu_req_valid),
    .req_lsu    (lsu_req_valid),
    .last_grant (last_grant),
    .gnt_ifu    (gnt_ifu),
    .gnt_lsu    (gnt_lsu)
  );

  assign ifu_req_ready = (state == ST_IDLE) && gnt_ifu;
  assign lsu_req_ready = (state == ST_IDLE) && gnt_lsu;
  assign hs_ifu        = ifu_req_valid && ifu_req_ready;
  assign hs_lsu        = lsu_req_valid && lsu_req_ready;
  assign owner_ready   = (owner_q == OWNER_IFU) ? ifu_resp_ready : lsu_resp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    mem_ren        = 1'b0;
    mem_raddr      = '0;
    mem_wen        = 1'b0;
    mem_waddr      = '0;
    mem_wdata      = '0;
    mem_wmask      = '0;
    ifu_resp_valid = 1'b0;
    ifu_resp_rdata = '0;
    lsu_resp_valid = 1'b0;
    lsu_resp_rdata = '0;
    case (state)
      ST_IDLE:  if (hs_ifu || hs_lsu) state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        state_nxt = (LATENCY == 0) ? ST_RESP : ST_WAIT;
        if (wen_q) begin
          mem_wen   = 1'b1;
          mem_waddr = addr_q;
          mem_wdata = wdata_q;
          mem_wmask = wmask_q;
        end else begin
          mem_ren   = 1'b1;
          mem_raddr = addr_q;
        end
      end
      ST_WAIT:  if (cnt == '0) state_nxt = ST_RESP;
      ST_RESP: begin
        if (owner_q == OWNER_IFU) begin
          ifu_resp_valid = 1'b1;
          ifu_resp_rdata = rdata_q;
        end else begin
          lsu_resp_valid = 1'b1;
          lsu_resp_rdata = rdata_q;
        end
        if (owner_ready) state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= OWNER_LSU;
      owner_q    <= OWNER_IFU;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      rdata_q    <= '0;
      cnt        <= '0;
    end else begin
      if (hs_ifu) begin
        owner_q    <= OWNER_IFU;
        last_grant <= OWNER_IFU;
        wen_q      <= 1'b0;
        addr_q     <= ifu_req_addr;
        wdata_q    <= '0;
        wmask_q    <= '0;
      end else if (hs_lsu) begin
        owner_q    <= OWNER_LSU;
        last_grant <= OWNER_LSU;
        wen_q      <= lsu_req_wen;
        addr_q     <= lsu_req_addr;
        wdata_q    <= lsu_req_wdata;
        wmask_q    <= lsu_req_wmask;
      end
      if (state == ST_ISSUE) begin
        rdata_q <= wen_q ? '0 : mem_rdata;
        cnt     <= CNT_LOAD;
      end else if (state == ST_WAIT && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule
